// File: rtl/dcache_ctrl.sv
// dcache_ctrl: miss sequencing for the 2-way, 16-set, 32-byte-line write-back
// data cache. Word hits are served combinationally. A miss stalls the CPU,
// writes back a dirty victim, refills the line and then replays the access.
module dcache_ctrl #(
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [255:0]          mem_data_o,
    input  logic [255:0]          mem_data_i,
    input  logic                  mem_ack_i,
    output logic [3:0]            sram_addr_o,
    output logic [24:0]           sram_tag_o,
    output logic [255:0]          sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [24:0]           sram_tag_i,
    input  logic [255:0]          sram_data_i,
    input  logic                  sram_hit_i
);

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [255:0]            mem_data_q, mem_data_d;
    logic [255:0]            line_q, line_d;

    logic [22:0] tag;
    logic [3:0]  idx;
    logic [2:0]  word;
    logic        hit;
    logic        unused_addr;

    assign tag         = cpu_addr_i[31:9];
    assign idx         = cpu_addr_i[8:5];
    assign word        = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];

    // A raw tag match only counts when the line is valid.
    assign hit = sram_hit_i & sram_tag_i[24];

    // Memory-side request is fully registered so it stays stable until ack.
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    // State and memory-request registers; reset aborts any transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            line_q     <= line_d;
        end
    end

    // Next state and next memory request; the victim is captured leaving MISS.
    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        line_d     = line_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i && !hit) state_d = MISS;
            end
            MISS: begin
                mem_en_d = 1'b1;
                if (sram_tag_i[24:23] == 2'b11) begin
                    state_d    = WRITEBACK;
                    mem_we_d   = 1'b1;
                    mem_addr_d = {sram_tag_i[22:0], idx, 5'b0};
                    mem_data_d = sram_data_i;
                end else begin
                    state_d    = READMISS;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cpu_addr_i[31:5], 5'b0};
                end
            end
            WRITEBACK: begin
                // Request stays up and turns into the line fetch.
                if (mem_ack_i) begin
                    state_d    = READMISS;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cpu_addr_i[31:5], 5'b0};
                end
            end
            READMISS: begin
                if (mem_ack_i) begin
                    state_d  = READMISSOK;
                    mem_en_d = 1'b0;
                    line_d   = mem_data_i;
                end
            end
            READMISSOK: state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // CPU and SRAM side outputs; only IDLE hits and the refill cycle write.
    always_comb begin
        cpu_data_o    = '0;
        cpu_stall_o   = 1'b0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        sram_data_o   = '0;
        sram_tag_o    = '0;
        sram_addr_o   = '0;
        if (!rst_i) begin
            if (cpu_req_i || state_q != IDLE) begin
                sram_addr_o       = idx;
                sram_tag_o[22:0]  = tag;
            end
            unique case (state_q)
                IDLE: begin
                    cpu_stall_o   = cpu_req_i & ~hit;
                    sram_enable_o = cpu_req_i;
                    if (cpu_req_i && hit) begin
                        if (cpu_write_i) begin
                            sram_write_o                    = 1'b1;
                            sram_data_o                     = sram_data_i;
                            sram_data_o[{word, 5'b0} +: 32] = cpu_data_i;
                            sram_tag_o[24:23]               = 2'b11;
                        end else begin
                            cpu_data_o = sram_data_i[{word, 5'b0} +: 32];
                        end
                    end
                end
                MISS: begin
                    cpu_stall_o   = 1'b1;
                    sram_enable_o = 1'b1;
                end
                READMISSOK: begin
                    cpu_stall_o       = 1'b1;
                    sram_enable_o     = 1'b1;
                    sram_write_o      = 1'b1;
                    sram_data_o       = line_q;
                    sram_tag_o[24:23] = 2'b10;
                end
                default: cpu_stall_o = 1'b1;
            endcase
        end
    end

endmodule
